// File: rtl/nes_pkg.sv
// nes_pkg: shared NES bus addresses and OAM DMA state encoding
package nes_pkg;
    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam logic [15:0] OAMDATA = 16'h2004;
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;
endpackage

// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-side and system-bus-side signals of the OAM DMA engine
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_d_out;
    logic        cpu_ready;
    logic [7:0]  bus_d_in;
    logic [15:0] bus_addr;
    logic        bus_write;
    logic [7:0]  bus_d_out;
    logic        busy;
    modport slave (
        input  cpu_addr, cpu_write, cpu_d_out, bus_d_in,
        output cpu_ready, bus_addr, bus_write, bus_d_out, busy
    );
    modport master (
        output cpu_addr, cpu_write, cpu_d_out, bus_d_in,
        input  cpu_ready, bus_addr, bus_write, bus_d_out, busy
    );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: halts the CPU and copies one 256-byte page into PPU OAM via OAMDATA
module oam_dma #(
    parameter logic [15:0] DMA_REG = nes_pkg::DMA_REG,
    parameter logic [15:0] OAMDATA = nes_pkg::OAMDATA
) (
    input  logic       clk,
    input  logic       reset,
    oam_dma_if.slave   bus
);
    import nes_pkg::*;
    dma_state_t state, state_n;
    logic [7:0] page, idx, buffer;
    logic       parity;
    logic       idle, trigger;
    assign idle    = state == IDLE;
    assign trigger = idle && bus.cpu_write && bus.cpu_addr == DMA_REG;
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            buffer <= 8'h00;
            parity <= 1'b0;
        end else begin
            state  <= state_n;
            parity <= ~parity;
            if (trigger) begin
                page <= bus.cpu_d_out;
                idx  <= 8'h00;
            end
            if (state == READ) buffer <= bus.bus_d_in;
            if (state == WRITE) idx <= idx + 8'h01;
        end
    end
    // an odd-cycle HALT needs one extra ALIGN cycle before the read/write pairs start
    always_comb begin
        state_n = state == IDLE  ? (trigger ? HALT : IDLE) :
                  state == HALT  ? (parity ? ALIGN : READ) :
                  state == ALIGN ? READ :
                  state == READ  ? WRITE :
                  (idx == 8'hFF ? IDLE : READ);
    end
    assign bus.cpu_ready = idle;
    assign bus.busy      = !idle;
    assign bus.bus_addr  = idle            ? bus.cpu_addr :
                           state == WRITE  ? OAMDATA :
                           state == READ   ? {page, idx} : {page, 8'h00};
    assign bus.bus_write = idle ? bus.cpu_write : state == WRITE;
    assign bus.bus_d_out = idle ? bus.cpu_d_out : state == WRITE ? buffer : 8'h00;
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameters: DMA_REG = 16'h4014, the register address that triggers a transfer; OAMDATA = 16'h2004, the PPU OAM data port.
REQ-002 clk  in  1  system clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cpu_addr  in  16  CPU address output.
REQ-005 cpu_write  in  1  CPU write strobe.
REQ-006 cpu_d_out  in  8  CPU write data.
REQ-007 cpu_ready  out  1  drives the CPU ready input; 0 halts the CPU.
REQ-008 bus_d_in  in  8  read data returned from the system bus.
REQ-009 bus_addr  out  16  system bus address.
REQ-010 bus_write  out  1  system bus write strobe.
REQ-011 bus_d_out  out  8  system bus write data.
REQ-012 busy  out  1  high whenever state != IDLE.

Function
REQ-013 The block SHALL use the states IDLE, HALT, ALIGN, READ and WRITE.
REQ-014 A 1-bit parity register SHALL toggle on every clk and SHALL read 0 in the first cycle after reset.
REQ-015 Trigger: in IDLE, cpu_write=1 with cpu_addr==DMA_REG SHALL latch cpu_d_out into page[7:0], clear idx[7:0] to 0 and go to HALT.
REQ-016 The triggering CPU write SHALL also pass through to the bus unchanged in that same cycle.
REQ-017 HALT SHALL go to ALIGN when parity==1, otherwise to READ; ALIGN SHALL go to READ after one cycle.
REQ-018 READ SHALL drive bus_addr={page,idx} with bus_write=0, capture bus_d_in into an 8-bit buffer at the clock edge, and go to WRITE.
REQ-019 WRITE SHALL drive bus_addr=OAMDATA, bus_write=1 and bus_d_out=buffer.
REQ-020 At the end of WRITE, idx SHALL increment; if idx was 8'hFF the next state SHALL be IDLE, otherwise READ.
REQ-021 idx SHALL wrap within the page with no carry into page (page FF covers $FF00-$FFFF only).
REQ-022 cpu_ready SHALL be combinational: 1 in IDLE, 0 in every other state.
REQ-023 The CPU SHALL be halted for exactly 513 cycles (parity 0 at HALT) or 514 cycles (parity 1 at HALT).
REQ-024 Bus mux, IDLE: bus_addr, bus_write and bus_d_out SHALL equal cpu_addr, cpu_write and cpu_d_out.
REQ-025 Bus mux, non-IDLE: CPU bus outputs SHALL be ignored.
REQ-026 Bus mux, HALT and ALIGN: bus_addr={page,8'h00}, bus_write=0, bus_d_out=0.
REQ-027 In any non-IDLE state, writes to DMA_REG SHALL be ignored.
REQ-028 Exactly 256 OAMDATA writes SHALL occur per transfer, in idx order 00..FF.
REQ-029 busy SHALL deassert in the same cycle that cpu_ready returns to 1.

Reset
REQ-030 On reset the state SHALL be IDLE and page, idx, buffer and parity SHALL be 0.
REQ-031 After reset, cpu_ready SHALL be 1, busy 0, and the bus SHALL be in CPU passthrough.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no further OAMDATA writes, and cpu_ready SHALL be 1 in the cycle after reset.
REQ-033 Reset SHALL take priority over a simultaneous trigger.

Structure
REQ-034 The shared package nes_pkg SHALL hold the DMA_REG and OAMDATA address constants and the dma_state_t enum.
REQ-035 The block SHALL be a single module with no sub-module; the bus mux SHALL remain inline combinational logic.

Verification
REQ-036 Trigger write $4014 <- 8'h02 with parity 0 at HALT -> cpu_ready low for 513 cycles; reads $0200..$02FF; 256 writes to $2004.
REQ-037 Same trigger with parity 1 at HALT -> one ALIGN cycle, cpu_ready low for 514 cycles, first READ one cycle later than in REQ-036.
REQ-038 Memory preloaded with mem[$0300+i]=i^8'hA5, trigger 8'h03 -> the k-th $2004 write carries k^8'hA5 for k=0..255.
REQ-039 Trigger 8'hFF -> last read at $FFFF, no access at $0000, state IDLE afterwards.
REQ-040 Reset asserted in the READ for idx=8'h40 -> no further $2004 writes, cpu_ready=1 next cycle, bus back in CPU passthrough.
REQ-041 CPU writes to $4015 and $4014-read (cpu_write=0) -> no trigger, busy stays 0, bus passthrough intact.
